// File: rtl/frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : frame_streamer                                                  |
// | Purpose  : Streams one raster frame from a pixel memory (1-cycle read      |
// |            latency) onto an Avalon-ST source with a 2-entry output buffer. |
// | Options  : TEST_PATTERN_EN adds pattern_sel (sampled at start); when set,  |
// |            8 vertical RGB444 colour bars replace the memory data.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module frame_streamer #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic [16:0]       rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              ready_in,
  output logic              valid_out,
  output logic              startofpacket_out,
  output logic              endofpacket_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [16:0] LAST_PIX = 17'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [16:0]       addr_q, addr_d;        // next read address
  logic [16:0]       beat_q, beat_d;        // index of the beat at the buffer head
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [2:0]        room_used;
  logic [DATA_W-1:0] fill_data;
  logic              xfer;
  logic              issue;

  // Occupancy counts the entry leaving this cycle as already gone, which keeps
  // the pipe full at one beat per cycle while never overfilling the buffer.
  assign xfer      = valid_out && ready_in;
  assign room_used = 3'(count_q) + 3'(inflight_q) - 3'(xfer);
  assign issue     = (state_q == RUN) && (room_used < 3'd2);

  assign valid_out         = (count_q != 2'd0);
  assign data_out          = valid_out ? buf_q[rd_ptr_q] : '0;
  assign startofpacket_out = valid_out && (beat_q == 17'd0);
  assign endofpacket_out   = valid_out && (beat_q == LAST_PIX);
  assign rd_addr           = addr_q;
  assign busy              = (state_q != IDLE);
  assign frame_done        = (state_q == DONE);

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = (IMG_W / 8 > 0) ? IMG_W / 8 : 1;

  logic              pat_mode_q, pat_mode_d;
  logic [16:0]       x_q, x_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [2:0]        bar;

  assign bar       = 3'(x_q / 17'(BAR_W));
  assign rd_en     = issue && !pat_mode_q;
  assign fill_data = pat_mode_q ? pat_q : rd_data;

  // Pattern generator mirrors the read timing: the pixel for column x becomes
  // available one cycle after its (suppressed) read would have been issued.
  always_comb begin
    pat_mode_d = pat_mode_q;
    x_d        = x_q;
    pat_d      = pat_q;
    if (state_q == IDLE && start) begin
      pat_mode_d = pattern_sel;
      x_d        = '0;
    end else if (issue) begin
      pat_d = DATA_W'({{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}});
      x_d   = (x_q == 17'(IMG_W - 1)) ? 17'd0 : x_q + 17'd1;
    end
  end

  // Pattern state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_mode_q <= 1'b0;
      x_q        <= '0;
      pat_q      <= '0;
    end else begin
      pat_mode_q <= pat_mode_d;
      x_q        <= x_d;
      pat_q      <= pat_d;
    end
  end
`else
  assign rd_en     = issue;
  assign fill_data = rd_data;
`endif

  // Next-state logic for the frame FSM, read address and output buffer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    inflight_d = issue;
    buf_d      = buf_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + 2'(inflight_q) - 2'(xfer);

    // Read data returning now is written behind the head entry.
    if (inflight_q) begin
      buf_d[wr_ptr_q] = fill_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (xfer) begin
      rd_ptr_d = ~rd_ptr_q;
      beat_d   = (beat_q == LAST_PIX) ? 17'd0 : beat_q + 17'd1;
    end

    case (state_q)
      IDLE: begin
        addr_d = '0;
        beat_d = '0;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (issue) begin
          if (addr_q == LAST_PIX) state_d = FLUSH;
          else                    addr_d  = addr_q + 17'd1;
        end
      end
      FLUSH: begin
        if (xfer && endofpacket_out) state_d = DONE;
      end
      DONE: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons the frame and drops any returning read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
      buf_q      <= buf_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_frame_streamer                                               |
// | Purpose  : Self-checking bench for frame_streamer: randomised downstream   |
// |            back-pressure against a frame-level reference model, plus a     |
// |            tiny 4x2 instance for back-to-back frames.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_frame_streamer;

  localparam int W = 80;
  localparam int H = 64;
  localparam int N = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, ready_in;
  logic        rd_en, valid_out, sop, eop, busy, frame_done;
  logic [16:0] rd_addr;
  logic [11:0] rd_data, data_out;
  logic [11:0] key;

  logic        s_start, s_ready;
  logic        s_rd_en, s_valid, s_sop, s_eop, s_busy, s_done;
  logic [16:0] s_rd_addr;
  logic [11:0] s_rd_data, s_data;

`ifdef TEST_PATTERN_EN
  logic pattern_sel = 1'b0;
`endif

  frame_streamer #(.IMG_W(W), .IMG_H(H), .DATA_W(12)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .ready_in(ready_in),
    .valid_out(valid_out), .startofpacket_out(sop), .endofpacket_out(eop),
    .data_out(data_out), .busy(busy), .frame_done(frame_done)
  );

  frame_streamer #(.IMG_W(4), .IMG_H(2), .DATA_W(12)) dut_small (
    .clk(clk), .reset(reset), .start(s_start),
`ifdef TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .rd_addr(s_rd_addr), .rd_en(s_rd_en), .rd_data(s_rd_data), .ready_in(s_ready),
    .valid_out(s_valid), .startofpacket_out(s_sop), .endofpacket_out(s_eop),
    .data_out(s_data), .busy(s_busy), .frame_done(s_done)
  );

  // Pixel memories: data valid one cycle after the strobe, garbage otherwise.
  always @(posedge clk) rd_data   <= rd_en ? (rd_addr[11:0] ^ key) : 12'($urandom);
  always @(posedge clk) s_rd_data <= s_rd_en ? s_rd_addr[11:0] : 12'($urandom);

  int total = 0;
  int bad   = 0;

  // Frame-level reference model state.
  bit          m_busy     = 1'b0;
  bit          done_pend  = 1'b0;
  bit          post_reset = 1'b1;
  bit          prev_stall = 1'b0;
  bit          seen_valid = 1'b0;
  bit          prev_sop, prev_eop;
  logic [11:0] prev_data;
  int          issued = 0;
  int          beats  = 0;
  int          cyc    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pick_ready(input bit random_ready);
    return random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // One clock cycle: drive inputs after the falling edge, check, update model.
  task automatic step(input bit st, input bit rdy, input bit rst);
    bit xfer, exp_done;
    @(negedge clk);
    start = st; ready_in = rdy; reset = rst;
    #1;
    exp_done = done_pend;
    chk("frame_done", 64'(frame_done), 64'(exp_done));
    chk("busy", 64'(busy), 64'(m_busy));
    if (post_reset)
      chk("reset_outputs", 64'({valid_out, sop, eop, data_out, rd_en, rd_addr, busy, frame_done}), 64'd0);
    if (!m_busy)
      chk("idle_quiet", 64'({valid_out, rd_en}), 64'd0);
    if (prev_stall)
      chk("stall_hold", 64'({valid_out, sop, eop, data_out}), 64'({1'b1, prev_sop, prev_eop, prev_data}));
    xfer = valid_out && rdy;
    if (rd_en) begin
      if (issued == 0) chk("first_rd_cycle", 64'(cyc), 64'd1);
      chk("rd_addr", 64'(rd_addr), 64'(issued));
      chk("rd_room", 64'((issued - beats - int'(xfer)) < 2), 64'd1);
      chk("rd_legal", 64'(m_busy && (issued < N)), 64'd1);
    end
    if (valid_out && m_busy && !seen_valid) begin
      chk("first_valid_cycle", 64'(cyc), 64'd3);
      seen_valid = 1'b1;
    end
    if (xfer)
      chk("beat", 64'({sop, eop, data_out}), 64'({beats == 0, beats == N - 1, 12'(beats) ^ key}));

    if (rd_en) issued++;
    done_pend = 1'b0;
    if (xfer) begin
      if (beats == N - 1) done_pend = 1'b1;
      beats++;
    end
    if (exp_done) chk("beat_count", 64'(beats), 64'(N));
    prev_stall = valid_out && !rdy;
    prev_sop   = sop;
    prev_eop   = eop;
    prev_data  = data_out;
    cyc++;
    post_reset = rst;
    if (rst) begin
      m_busy = 1'b0; issued = 0; beats = 0; done_pend = 1'b0;
      prev_stall = 1'b0; seen_valid = 1'b0;
    end else if (!m_busy && st) begin
      m_busy = 1'b1; issued = 0; beats = 0; cyc = 1; seen_valid = 1'b0;
    end else if (exp_done) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic run_frame(input bit random_ready, input int restart_at, input int reset_at);
    int guard = 0;
    bit restarted = 1'b0;
    bit st, rst;
    step(1'b1, pick_ready(random_ready), 1'b0);
    while (m_busy && guard < 4 * N + 100) begin
      rst = (reset_at >= 0) && (beats >= reset_at);
      st  = (restart_at >= 0) && !restarted && (beats >= restart_at);
      if (st) restarted = 1'b1;
      step(st, pick_ready(random_ready), rst);
      guard++;
    end
    chk("frame_finished", 64'(m_busy), 64'd0);
    repeat (2) step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bit          exp_v;
    int          idx;
    reset = 1'b1; start = 1'b0; ready_in = 1'b0; key = 12'h000;
    s_start = 1'b0; s_ready = 1'b1;

    // Reset, then reset and start together: reset must win.
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b0);

    // Full-rate frame, memory data = address.
    run_frame(1'b0, -1, -1);

    // Random back-pressure with a scrambled memory image.
    key = 12'($urandom);
    run_frame(1'b1, -1, -1);

    // Start pulsed mid-frame must be ignored.
    key = 12'($urandom);
    run_frame(1'b1, 1000, -1);

    // Reset mid-frame, then a fresh complete frame.
    key = 12'h000;
    run_frame(1'b0, -1, 5000);
    key = 12'($urandom);
    run_frame(1'b1, -1, -1);

    // 4x2 instance: start at cycle 0 and again in the cycle after DONE.
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      s_start = (c == 0) || (c == 12);
      #1;
      exp_v = ((c >= 3) && (c <= 10)) || ((c >= 15) && (c <= 22));
      idx   = (c >= 15) ? c - 15 : c - 3;
      chk("small_valid", 64'(s_valid), 64'(exp_v));
      chk("small_done", 64'(s_done), 64'((c == 11) || (c == 23)));
      if (exp_v)
        chk("small_beat", 64'({s_sop, s_eop, s_data}), 64'({idx == 0, idx == 7, 12'(idx)}));
    end
    s_start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
